// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared physical memory port.
// The arbiter attaches through the slave modport; the datapath/memory
// side (or a testbench) uses the master modport.
interface mem_port_arbiter_if;
  // Port a: instruction fetch, read-only
  logic        mem_read_a;
  logic [15:0] mem_address_a;
  logic        mem_resp_a;
  logic [15:0] mem_rdata_a;
  // Port b: data, read/write with byte mask
  logic        mem_read_b;
  logic        mem_write_b;
  logic [1:0]  mem_wmask_b;
  logic [15:0] mem_address_b;
  logic [15:0] mem_wdata_b;
  logic        mem_resp_b;
  logic [15:0] mem_rdata_b;
  // Shared physical port
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_wmask;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;
  // Sticky error flag
  logic        timeout_err;

  modport slave (
    input  mem_read_a, mem_address_a,
    output mem_resp_a, mem_rdata_a,
    input  mem_read_b, mem_write_b, mem_wmask_b, mem_address_b, mem_wdata_b,
    output mem_resp_b, mem_rdata_b,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask,
    input  pmem_resp, pmem_rdata,
    output timeout_err
  );

  modport master (
    output mem_read_a, mem_address_a,
    input  mem_resp_a, mem_rdata_a,
    output mem_read_b, mem_write_b, mem_wmask_b, mem_address_b, mem_wdata_b,
    input  mem_resp_b, mem_rdata_b,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask,
    output pmem_resp, pmem_rdata,
    input  timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between an instruction-fetch port (a)
// and a data port (b). One port is granted at a time; its request is
// latched on the grant edge and the physical port is driven only from
// those latches until the memory answers. Ties alternate between ports.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  state_t        state;
  state_t        state_next;
  logic          last_grant_b;   // 1: port b was granted most recently
  logic          grant_a;
  logic          grant_b;
  logic          req_a;
  logic          req_b;
  logic [15:0]   addr_lat;
  logic [15:0]   wdata_lat;
  logic [1:0]    wmask_lat;
  logic          op_write;       // latched operation: 1 = write, 0 = read
  logic [CW-1:0] to_cnt;
  logic [CW-1:0] to_cnt_next;
  logic          to_err;
  logic          serving;

  assign req_a = bus.mem_read_a;
  assign req_b = bus.mem_read_b | bus.mem_write_b;

  // Next-state, grant decision and timeout counter update
  always_comb begin
    state_next  = state;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    to_cnt_next = to_cnt;
    case (state)
      IDLE: begin
        to_cnt_next = {CW{1'b0}};
        if (req_a && req_b) begin
          // Round-robin: the port that did not go last wins the tie
          if (last_grant_b) begin
            grant_a = 1'b1;
          end else begin
            grant_b = 1'b1;
          end
        end else if (req_a) begin
          grant_a = 1'b1;
        end else if (req_b) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b0;
        end
        if (grant_a) begin
          state_next = SERVE_A;
        end else if (grant_b) begin
          state_next = SERVE_B;
        end else begin
          state_next = IDLE;
        end
      end
      SERVE_A, SERVE_B: begin
        if (bus.pmem_resp) begin
          state_next  = IDLE;
          to_cnt_next = {CW{1'b0}};
        end else if (to_cnt != TO_LIMIT) begin
          to_cnt_next = to_cnt + CW'(1);
        end else begin
          to_cnt_next = to_cnt;
        end
      end
      default: begin
        state_next  = IDLE;
        to_cnt_next = {CW{1'b0}};
      end
    endcase
  end

  // State register, timeout counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      to_cnt <= {CW{1'b0}};
      to_err <= 1'b0;
    end else begin
      state  <= state_next;
      to_cnt <= to_cnt_next;
      to_err <= to_err | (to_cnt_next == TO_LIMIT);
    end
  end

  // Capture the granted request; port b read+write latches as a write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_lat     <= 16'h0000;
      wdata_lat    <= 16'h0000;
      wmask_lat    <= 2'b00;
      op_write     <= 1'b0;
      last_grant_b <= 1'b1;
    end else if (grant_a) begin
      addr_lat     <= bus.mem_address_a;
      wdata_lat    <= 16'h0000;
      wmask_lat    <= 2'b11;
      op_write     <= 1'b0;
      last_grant_b <= 1'b0;
    end else if (grant_b) begin
      addr_lat     <= bus.mem_address_b;
      wdata_lat    <= bus.mem_wdata_b;
      wmask_lat    <= bus.mem_wmask_b;
      op_write     <= bus.mem_write_b;
      last_grant_b <= 1'b1;
    end
  end

  assign serving = (state == SERVE_A) || (state == SERVE_B);

  // Physical port is driven purely from the latches while serving
  assign bus.pmem_read    = serving & ~op_write;
  assign bus.pmem_write   = serving & op_write;
  assign bus.pmem_address = addr_lat;
  assign bus.pmem_wdata   = wdata_lat;
  assign bus.pmem_wmask   = wmask_lat;

  // Responses route to whichever port owns the physical port this cycle
  assign bus.mem_resp_a  = bus.pmem_resp & (state == SERVE_A);
  assign bus.mem_resp_b  = bus.pmem_resp & (state == SERVE_B);
  assign bus.mem_rdata_a = bus.pmem_rdata;
  assign bus.mem_rdata_b = bus.pmem_rdata;

  assign bus.timeout_err = to_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a short timeout (4 cycles).
// Inputs change 2 time units after each rising edge; outputs are checked
// 1 unit later, well clear of the next edge.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    vectors = 0;
    miscompares = 0;
    bus.mem_read_a    = 1'b0;
    bus.mem_address_a = 16'h0000;
    bus.mem_read_b    = 1'b0;
    bus.mem_write_b   = 1'b0;
    bus.mem_wmask_b   = 2'b00;
    bus.mem_address_b = 16'h0000;
    bus.mem_wdata_b   = 16'h0000;
    bus.pmem_resp     = 1'b0;
    bus.pmem_rdata    = 16'h0000;

    // Reset state
    cyc(); cyc();
    chk("rst_pmem_read", 32'(bus.pmem_read), 32'd0);
    chk("rst_pmem_write", 32'(bus.pmem_write), 32'd0);
    chk("rst_pmem_address", 32'(bus.pmem_address), 32'h0);
    chk("rst_pmem_wmask", 32'(bus.pmem_wmask), 32'd0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    rst = 1'b0;
    cyc();

    // Stray pmem_resp in IDLE gives no response to either port
    bus.pmem_resp = 1'b1;
    #1;
    chk("idle_resp_a", 32'(bus.mem_resp_a), 32'd0);
    chk("idle_resp_b", 32'(bus.mem_resp_b), 32'd0);
    cyc();
    bus.pmem_resp = 1'b0;
    #1;
    chk("idle_stays", 32'(bus.pmem_read), 32'd0);

    // Test 1: port a read 0x1000, memory answers 3 cycles later with 0xBEEF
    cyc();
    bus.mem_read_a    = 1'b1;
    bus.mem_address_a = 16'h1000;
    cyc();
    chk("t1_pmem_read", 32'(bus.pmem_read), 32'd1);
    chk("t1_pmem_write", 32'(bus.pmem_write), 32'd0);
    chk("t1_pmem_address", 32'(bus.pmem_address), 32'h1000);
    chk("t1_pmem_wmask", 32'(bus.pmem_wmask), 32'h3);
    chk("t1_no_early_resp", 32'(bus.mem_resp_a), 32'd0);
    cyc(); cyc();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 16'hBEEF;
    #1;
    chk("t1_resp_a", 32'(bus.mem_resp_a), 32'd1);
    chk("t1_rdata_a", 32'(bus.mem_rdata_a), 32'hBEEF);
    chk("t1_resp_b_quiet", 32'(bus.mem_resp_b), 32'd0);
    cyc();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 16'h0000;
    bus.mem_read_a = 1'b0;
    #1;
    chk("t1_idle_read", 32'(bus.pmem_read), 32'd0);
    chk("t1_resp_single", 32'(bus.mem_resp_a), 32'd0);
    chk("t1_no_timeout", 32'(bus.timeout_err), 32'd0);

    // Test 2: reset, then A read and B write together; A first
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    bus.mem_read_a    = 1'b1;
    bus.mem_address_a = 16'h0040;
    bus.mem_write_b   = 1'b1;
    bus.mem_address_b = 16'h2002;
    bus.mem_wdata_b   = 16'h1234;
    bus.mem_wmask_b   = 2'b01;
    cyc();
    chk("t2_a_first_read", 32'(bus.pmem_read), 32'd1);
    chk("t2_a_first_write", 32'(bus.pmem_write), 32'd0);
    chk("t2_a_addr", 32'(bus.pmem_address), 32'h0040);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 16'h5A5A;
    #1;
    chk("t2_min_latency_resp_a", 32'(bus.mem_resp_a), 32'd1);
    chk("t2_rdata_a", 32'(bus.mem_rdata_a), 32'h5A5A);
    chk("t2_resp_b_quiet", 32'(bus.mem_resp_b), 32'd0);
    cyc();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 16'h0000;
    bus.mem_read_a = 1'b0;
    #1;
    chk("t2_gap_read", 32'(bus.pmem_read), 32'd0);
    chk("t2_gap_write", 32'(bus.pmem_write), 32'd0);
    cyc();
    chk("t2_b_write", 32'(bus.pmem_write), 32'd1);
    chk("t2_b_read", 32'(bus.pmem_read), 32'd0);
    chk("t2_b_addr", 32'(bus.pmem_address), 32'h2002);
    chk("t2_b_wdata", 32'(bus.pmem_wdata), 32'h1234);
    chk("t2_b_wmask", 32'(bus.pmem_wmask), 32'h1);

    // Test 3: port b inputs change after grant; physical port holds
    bus.mem_address_b = 16'hFFFF;
    bus.mem_wdata_b   = 16'h0000;
    bus.mem_wmask_b   = 2'b10;
    cyc();
    chk("t3_addr_held", 32'(bus.pmem_address), 32'h2002);
    chk("t3_wdata_held", 32'(bus.pmem_wdata), 32'h1234);
    chk("t3_wmask_held", 32'(bus.pmem_wmask), 32'h1);
    bus.pmem_resp = 1'b1;
    #1;
    chk("t3_resp_b", 32'(bus.mem_resp_b), 32'd1);
    chk("t3_resp_a_quiet", 32'(bus.mem_resp_a), 32'd0);
    cyc();
    bus.pmem_resp   = 1'b0;
    bus.mem_write_b = 1'b0;
    #1;
    chk("t3_idle_write", 32'(bus.pmem_write), 32'd0);

    // Next tie after B was served goes to A; B read+write latches as write
    bus.mem_read_a    = 1'b1;
    bus.mem_address_a = 16'h0A0A;
    bus.mem_read_b    = 1'b1;
    bus.mem_write_b   = 1'b1;
    bus.mem_address_b = 16'h3000;
    bus.mem_wdata_b   = 16'hC0DE;
    bus.mem_wmask_b   = 2'b11;
    cyc();
    chk("tie2_a_read", 32'(bus.pmem_read), 32'd1);
    chk("tie2_a_addr", 32'(bus.pmem_address), 32'h0A0A);
    bus.pmem_resp = 1'b1;
    cyc();
    bus.pmem_resp  = 1'b0;
    bus.mem_read_a = 1'b0;
    cyc();
    chk("rw_write_wins", 32'(bus.pmem_write), 32'd1);
    chk("rw_no_read", 32'(bus.pmem_read), 32'd0);
    chk("rw_addr", 32'(bus.pmem_address), 32'h3000);

    // Test 4: no response, timeout after 4 SERVE cycles
    cyc(); cyc(); cyc();
    chk("t4_before_limit", 32'(bus.timeout_err), 32'd0);
    cyc();
    chk("t4_at_limit", 32'(bus.timeout_err), 32'd1);
    // Requester drops request mid-SERVE: transaction stays on the port
    bus.mem_read_b  = 1'b0;
    bus.mem_write_b = 1'b0;
    cyc();
    chk("t4_still_waiting", 32'(bus.pmem_write), 32'd1);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 16'h7777;
    #1;
    chk("t4_late_resp_b", 32'(bus.mem_resp_b), 32'd1);
    chk("t4_late_rdata_b", 32'(bus.mem_rdata_b), 32'h7777);
    cyc();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 16'h0000;
    #1;
    chk("t4_idle_after", 32'(bus.pmem_write), 32'd0);
    chk("t4_err_sticky", 32'(bus.timeout_err), 32'd1);

    // Test 5: reset while serving port b
    bus.mem_read_b    = 1'b1;
    bus.mem_address_b = 16'h4444;
    bus.mem_wmask_b   = 2'b10;
    cyc();
    chk("t5_serving", 32'(bus.pmem_read), 32'd1);
    bus.mem_read_b = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_read", 32'(bus.pmem_read), 32'd0);
    chk("t5_rst_addr", 32'(bus.pmem_address), 32'h0);
    chk("t5_rst_wmask", 32'(bus.pmem_wmask), 32'd0);
    chk("t5_rst_err", 32'(bus.timeout_err), 32'd0);
    bus.pmem_resp = 1'b1;
    #1;
    chk("t5_rst_drop_resp", 32'(bus.mem_resp_b), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("t5_idle_resp_b", 32'(bus.mem_resp_b), 32'd0);
    chk("t5_idle_read", 32'(bus.pmem_read), 32'd0);
    bus.pmem_resp = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
